alu_seq: RTL

Parametrised, registered successor to the combinational 16-bit ALU. It keeps the existing operation set and adds iterative multiply, divide and remainder behind a start/done handshake. It sits in the CPU execute stage: the controller issues an operation with `start`, stalls on `busy`, and captures `out` and the flags on `done`.

---
 rtl/alu_seq.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Registered ALU for the execute stage: single-cycle ops finish in one cycle,
// while multiply/divide/remainder iterate WIDTH steps behind a start/done handshake.
module alu_seq #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned IMM_BITS = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       f,
  input  logic             sext,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             carry_out,
  output logic             dbz
);

  localparam int unsigned CNT_W = 6;
  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_SHL   = 4'd4;
  localparam logic [3:0] OP_SHR   = 4'd5;
  localparam logic [3:0] OP_MERGE = 4'd6;
  localparam logic [3:0] OP_MUL   = 4'd7;
  localparam logic [3:0] OP_DIV   = 4'd8;
  localparam logic [3:0] OP_REM   = 4'd9;
  localparam logic [WIDTH-1:0] IMM_MASK = WIDTH'((64'd1 << IMM_BITS) - 64'd1);
  localparam logic [WIDTH-1:0] SHIFT_LIM = WIDTH'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             cy_q, cy_d;
  logic             dbz_q, dbz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] sc_out;
  logic             sc_cy;
  logic [WIDTH:0]   sc_sum;
  logic [WIDTH:0]   sc_dif;
  logic             is_iter;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_n;
  logic [WIDTH-1:0] mul_lo_n;
  logic [WIDTH:0]   div_r;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem_n;
  logic [WIDTH-1:0] div_quo_n;
  logic             y_zero;

  // Single-cycle datapath, evaluated on the raw inputs at accept time.
  always_comb begin : single_op
    sc_sum = {1'b0, x} + {1'b0, y};
    sc_dif = {1'b0, x} - {1'b0, y};
    sc_out = sc_sum[WIDTH-1:0];
    sc_cy  = sc_sum[WIDTH];
    case (f)
      OP_ADD: begin
        if (sext) begin
          sc_out = {{(WIDTH-8){x[7]}}, x[7:0]};
          sc_cy  = 1'b0;
        end
      end
      OP_SUB: begin
        sc_out = sc_dif[WIDTH-1:0];
        sc_cy  = sc_dif[WIDTH];
      end
      OP_AND: begin
        sc_out = x & y;
        sc_cy  = 1'b0;
      end
      OP_OR: begin
        sc_out = x | y;
        sc_cy  = 1'b0;
      end
      OP_SHL: begin
        sc_out = (y >= SHIFT_LIM) ? '0 : (x << y);
        sc_cy  = 1'b0;
      end
      OP_SHR: begin
        sc_out = (y >= SHIFT_LIM) ? '0 : (x >> y);
        sc_cy  = 1'b0;
      end
      OP_MERGE: begin
        sc_out = (x << IMM_BITS) | (y & IMM_MASK);
        sc_cy  = 1'b0;
      end
      default: ;
    endcase
    is_iter = (f == OP_MUL) || (f == OP_DIV) || (f == OP_REM);
  end

  // One iteration step: shift-add multiply and restoring divide share hi/lo.
  always_comb begin : iter_step
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, x_q} : '0);
    mul_hi_n  = mul_sum[WIDTH:1];
    mul_lo_n  = {mul_sum[0], lo_q[WIDTH-1:1]};
    div_r     = {hi_q, lo_q[WIDTH-1]};
    div_ge    = div_r >= {1'b0, y_q};
    div_rem_n = div_ge ? WIDTH'(div_r - {1'b0, y_q}) : div_r[WIDTH-1:0];
    div_quo_n = {lo_q[WIDTH-2:0], div_ge};
    y_zero    = (y_q == '0);
  end

  // Next-state and result logic.
  always_comb begin : next_state
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    x_d     = x_q;
    y_d     = y_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    out_d   = out_q;
    cy_d    = cy_q;
    dbz_d   = dbz_q;
    case (state_q)
      S_RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (op_q == OP_MUL) begin
          hi_d = mul_hi_n;
          lo_d = mul_lo_n;
        end else begin
          hi_d = div_rem_n;
          lo_d = div_quo_n;
        end
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_DONE;
          case (op_q)
            OP_MUL: begin
              out_d = mul_lo_n;
              cy_d  = |mul_hi_n;
              dbz_d = 1'b0;
            end
            OP_DIV: begin
              out_d = div_quo_n;
              cy_d  = y_zero;
              dbz_d = y_zero;
            end
            default: begin
              out_d = div_rem_n;
              cy_d  = y_zero;
              dbz_d = y_zero;
            end
          endcase
        end
      end
      default: begin
        // IDLE and DONE both accept; a DONE without a new start drops to IDLE.
        if (start) begin
          op_d = f;
          x_d  = x;
          y_d  = y;
          if (is_iter) begin
            state_d = S_RUN;
            cnt_d   = CNT_W'(WIDTH);
            hi_d    = '0;
            lo_d    = (f == OP_MUL) ? y : x;
          end else begin
            state_d = S_DONE;
            out_d   = sc_out;
            cy_d    = sc_cy;
            dbz_d   = 1'b0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      out_q   <= '0;
      cy_q    <= 1'b0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      x_q     <= x_d;
      y_q     <= y_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      out_q   <= out_d;
      cy_q    <= cy_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign out       = out_q;
  assign carry_out = cy_q;
  assign dbz       = dbz_q;

endmodule
